// File: rtl/cryp_pkg.sv
// Shared constants and bitwise helpers for the chained XOR/rotate cipher.
package cryp_pkg;

   // Chaining seed used by the original 16-bit core.
   localparam logic [15:0] CRYP_IV_DEFAULT = 16'h1234;

   // Per-beat mode encoding.
   typedef logic cryp_mode_t;
   localparam cryp_mode_t MODE_ENC = 1'b0;
   localparam cryp_mode_t MODE_DEC = 1'b1;

   // Widest lane the rotate/popcount helpers handle; lanes must be narrower.
   localparam int ROT_MAX_W = 64;
   typedef logic [ROT_MAX_W-1:0] rot_word_t;

   // Number of set bits in x.
   function automatic logic [6:0] popcount(input rot_word_t x);
      logic [6:0] c;
      c = '0;
      for (int i = 0; i < ROT_MAX_W; i++) begin
         c = c + 7'(x[i]);
      end
      return c;
   endfunction

   // Mask selecting the low w bits.
   function automatic rot_word_t width_mask(input int unsigned w);
      if (w >= ROT_MAX_W) begin
         return '1;
      end
      return (rot_word_t'(1) << w) - rot_word_t'(1);
   endfunction

   // Rotate left within the low w bits; amt must be below w.
   function automatic rot_word_t rotl(input rot_word_t x, input int unsigned amt,
                                      input int unsigned w);
      rot_word_t m;
      rot_word_t xm;
      m  = width_mask(w);
      xm = x & m;
      return ((xm << amt) | (xm >> (w - amt))) & m;
   endfunction

   // Rotate right within the low w bits; amt must be below w.
   function automatic rot_word_t rotr(input rot_word_t x, input int unsigned amt,
                                      input int unsigned w);
      rot_word_t m;
      rot_word_t xm;
      m  = width_mask(w);
      xm = x & m;
      return ((xm >> amt) | (xm << (w - amt))) & m;
   endfunction

endpackage

// File: rtl/chain_cipher_lane.sv
// One combinational cipher lane: result plus the chain value for the next lane.
module chain_cipher_lane
   import cryp_pkg::*;
#(
   parameter int LANE_W = 16,
   parameter int CNT_W  = $clog2(LANE_W + 1)
) (
   input  logic              mode,
   input  logic [LANE_W-1:0] data,
   input  logic [LANE_W-1:0] key,
   input  logic [CNT_W-1:0]  cnt,
   input  logic [LANE_W-1:0] chain_in,
   output logic [LANE_W-1:0] result,
   output logic [LANE_W-1:0] chain_out
);

   logic [CNT_W-1:0]            amt;
   rot_word_t                   rot_in;
   logic [ROT_MAX_W-1:LANE_W]   rot_unused;
   logic [LANE_W-1:0]           rot_lo;

   // Encrypt: rotl(d ^ p) ^ k, chain on result. Decrypt: rotr(d ^ k) ^ p, chain on input.
   always_comb begin
      // A full-weight key rotates by zero (count mod LANE_W).
      amt = (cnt == CNT_W'(LANE_W)) ? '0 : cnt;
      if (mode == MODE_DEC) begin
         rot_in                = ROT_MAX_W'(data ^ key);
         {rot_unused, rot_lo}  = rotr(rot_in, 32'(amt), LANE_W);
         result                = rot_lo ^ chain_in;
         chain_out             = data;
      end else begin
         rot_in                = ROT_MAX_W'(data ^ chain_in);
         {rot_unused, rot_lo}  = rotl(rot_in, 32'(amt), LANE_W);
         result                = rot_lo ^ key;
         chain_out             = result;
      end
   end

endmodule

// File: rtl/chain_cipher_pipe.sv
// Lane-serial chained XOR/rotate cipher with a globally stalled pipeline.
//
// Handshake: a beat moves on an edge where valid && ready. The whole pipe
// advances together (adv = !out_valid || out_ready); when adv is low every
// stage holds, out_valid/out_data/out_last stay stable and in_ready is low.
module chain_cipher_pipe
   import cryp_pkg::*;
#(
   parameter int                LANE_W = 16,
   parameter int                LANES  = 4,
   parameter logic [LANE_W-1:0] IV     = LANE_W'(CRYP_IV_DEFAULT),
   parameter int                CNT_W  = $clog2(LANE_W + 1)
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic                    in_mode,
   input  logic [LANES*LANE_W-1:0] in_key,
   input  logic [LANES*LANE_W-1:0] in_data,
   input  logic                    in_last,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [LANES*LANE_W-1:0] out_data,
   output logic                    out_last
);

   localparam int DW = LANES * LANE_W;
   localparam int CW = LANES * CNT_W;

   logic adv;

   // Stage 0 is the input register; stage j has lanes 0..j-1 finished.
   logic [LANES:0]    v_q;
   logic [LANES:0]    last_q;
   logic [LANES-1:0]  mode_q;
   logic [DW-1:0]     work_q  [0:LANES];
   logic [DW-1:0]     key_q   [0:LANES-1];
   logic [CW-1:0]     cnt_q   [0:LANES-1];
   logic [LANE_W-1:0] chain_q [1:LANES];

   logic              out_valid_q;
   logic              out_last_q;
   logic [DW-1:0]     out_data_q;

   logic [CW-1:0]     cnt_in;
   logic [LANE_W-1:0] chain_sel  [0:LANES-1];
   logic [LANE_W-1:0] lane_res   [0:LANES-1];
   logic [LANE_W-1:0] lane_chain [0:LANES-1];
   logic [DW-1:0]     work_nxt   [0:LANES-1];

   assign adv       = !out_valid_q || out_ready;
   assign in_ready  = adv;
   assign out_valid = out_valid_q;
   assign out_last  = out_last_q;
   assign out_data  = out_data_q;

   // Per-lane key popcounts, registered alongside the beat in stage 0.
   always_comb begin
      cnt_in = '0;
      for (int l = 0; l < LANES; l++) begin
         cnt_in[l*CNT_W +: CNT_W] = CNT_W'(popcount(ROT_MAX_W'(in_key[l*LANE_W +: LANE_W])));
      end
   end

   // Chain into lane 0 is the seed; later lanes use the previous stage's chain.
   always_comb begin
      for (int i = 0; i < LANES; i++) begin
         chain_sel[i] = IV;
      end
      for (int i = 1; i < LANES; i++) begin
         chain_sel[i] = chain_q[i];
      end
   end

   for (genvar i = 0; i < LANES; i++) begin : g_lane
      chain_cipher_lane #(
         .LANE_W (LANE_W),
         .CNT_W  (CNT_W)
      ) u_lane (
         .mode      (mode_q[i]),
         .data      (work_q[i][i*LANE_W +: LANE_W]),
         .key       (key_q[i][i*LANE_W +: LANE_W]),
         .cnt       (cnt_q[i][i*CNT_W +: CNT_W]),
         .chain_in  (chain_sel[i]),
         .result    (lane_res[i]),
         .chain_out (lane_chain[i])
      );
   end

   // Each stage replaces its own lane of the working vector with the lane result.
   always_comb begin
      for (int i = 0; i < LANES; i++) begin
         work_nxt[i]                      = work_q[i];
         work_nxt[i][i*LANE_W +: LANE_W]  = lane_res[i];
      end
   end

   // Valid/last chain and output register; reset discards everything in flight.
   always_ff @(posedge clk) begin
      if (reset) begin
         v_q         <= '0;
         last_q      <= '0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
         out_data_q  <= '0;
      end else if (adv) begin
         v_q         <= {v_q[LANES-1:0], in_valid};
         last_q      <= {last_q[LANES-1:0], in_valid & in_last};
         out_valid_q <= v_q[LANES];
         out_last_q  <= last_q[LANES];
         out_data_q  <= work_q[LANES];
      end
   end

   // Unreset datapath registers, moving only on a global advance.
   always_ff @(posedge clk) begin
      if (adv) begin
         mode_q[0] <= in_mode;
         work_q[0] <= in_data;
         key_q[0]  <= in_key;
         cnt_q[0]  <= cnt_in;
         for (int j = 1; j <= LANES; j++) begin
            work_q[j]  <= work_nxt[j-1];
            chain_q[j] <= lane_chain[j-1];
         end
         for (int j = 1; j < LANES; j++) begin
            mode_q[j] <= mode_q[j-1];
            key_q[j]  <= key_q[j-1];
            cnt_q[j]  <= cnt_q[j-1];
         end
      end
   end

endmodule

// File: tb/tb_chain_cipher_pipe.sv
// Directed bench for chain_cipher_pipe (default build plus an 8x8-bit build).
module tb_chain_cipher_pipe;

   logic        clk;
   logic        reset;
   logic        in_valid, in_ready, in_mode, in_last;
   logic [63:0] in_key, in_data;
   logic        out_valid, out_ready, out_last;
   logic [63:0] out_data;

   logic        b_in_valid, b_in_ready, b_in_mode, b_in_last;
   logic [63:0] b_in_key, b_in_data;
   logic        b_out_valid, b_out_ready, b_out_last;
   logic [63:0] b_out_data;

   int total;
   int bad;

   logic [63:0] exp_q[$];
   logic        exp_last_q[$];
   logic [63:0] got_q[$];
   logic [63:0] bk[$];
   logic [63:0] bd[$];
   logic        bm[$];
   logic        bl[$];

   chain_cipher_pipe dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_mode   (in_mode),
      .in_key    (in_key),
      .in_data   (in_data),
      .in_last   (in_last),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_last  (out_last)
   );

   chain_cipher_pipe #(
      .LANE_W (8),
      .LANES  (8),
      .IV     (8'hA5)
   ) dut8 (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (b_in_valid),
      .in_ready  (b_in_ready),
      .in_mode   (b_in_mode),
      .in_key    (b_in_key),
      .in_data   (b_in_data),
      .in_last   (b_in_last),
      .out_valid (b_out_valid),
      .out_ready (b_out_ready),
      .out_data  (b_out_data),
      .out_last  (b_out_last)
   );

   // Clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Reference cipher for the default 4x16 build, written from the lane equations.
   function automatic logic [63:0] model(input logic mode, input logic [63:0] key,
                                         input logic [63:0] data);
      logic [15:0] p, k, d, x, r;
      logic [63:0] res;
      int n;
      res = '0;
      p   = 16'h1234;
      for (int i = 0; i < 4; i++) begin
         k = key[i*16 +: 16];
         d = data[i*16 +: 16];
         n = $countones(k) % 16;
         if (!mode) begin
            x = d ^ p;
            r = (x << n) | (x >> (16 - n));
            r = r ^ k;
            p = r;
         end else begin
            x = d ^ k;
            r = (x >> n) | (x << (16 - n));
            r = r ^ p;
            p = d;
         end
         res[i*16 +: 16] = r;
      end
      return res;
   endfunction

   task automatic push_beat(input logic mode, input logic [63:0] key, input logic [63:0] data,
                            input logic last, input logic [63:0] exp);
      bm.push_back(mode);
      bk.push_back(key);
      bd.push_back(data);
      bl.push_back(last);
      exp_q.push_back(exp);
      exp_last_q.push_back(last);
   endtask

   task automatic clear_beats();
      bm.delete();
      bk.delete();
      bd.delete();
      bl.delete();
   endtask

   // Single beat into an idle pipe; checks latency, data, last and drain.
   task automatic one_beat(input string tag, input logic mode, input logic [63:0] key,
                           input logic [63:0] data, input logic last, input logic [63:0] exp);
      int lat;
      in_valid  = 1'b1;
      in_mode   = mode;
      in_key    = key;
      in_data   = data;
      in_last   = last;
      out_ready = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      chk({tag, "_latency"}, 64'(lat), 64'd5);
      chk({tag, "_data"}, out_data, exp);
      chk({tag, "_last"}, 64'(out_last), 64'(last));
      @(posedge clk); #1;
      chk({tag, "_drain"}, 64'(out_valid), 64'd0);
   endtask

   // Streams the queued beats with optional stall window and random bubbles.
   task automatic stream(input string tag, input int stall_at, input int stall_len,
                         input bit bubbles);
      int n, sent, recv, cyc;
      bit prev_stall, acc, emit;
      n = bk.size();
      sent = 0;
      recv = 0;
      cyc = 0;
      prev_stall = 1'b0;
      while (recv < n && cyc < 20 * n + 50) begin
         out_ready = !(cyc >= stall_at && cyc < stall_at + stall_len);
         in_valid  = (sent < n) && (!bubbles || ($urandom_range(0, 3) != 0));
         if (sent < n) begin
            in_key  = bk[sent];
            in_data = bd[sent];
            in_mode = bm[sent];
            in_last = bl[sent];
         end
         #1;
         if (prev_stall) chk({tag, "_stall_hold"}, 64'(out_valid), 64'd1);
         chk({tag, "_in_ready"}, 64'(in_ready), 64'(!out_valid || out_ready));
         if (out_valid) begin
            if (exp_q.size() == 0) begin
               chk({tag, "_extra_beat"}, 64'(out_valid), 64'd0);
            end else begin
               chk({tag, "_data"}, out_data, exp_q[0]);
               chk({tag, "_last"}, 64'(out_last), 64'(exp_last_q[0]));
            end
         end
         emit = out_valid && out_ready;
         acc  = in_valid && in_ready;
         prev_stall = out_valid && !out_ready;
         if (emit && exp_q.size() > 0) begin
            got_q.push_back(out_data);
            void'(exp_q.pop_front());
            void'(exp_last_q.pop_front());
            recv++;
         end
         @(posedge clk); #1;
         if (acc) sent++;
         cyc++;
      end
      chk({tag, "_delivered"}, 64'(recv), 64'(n));
      in_valid  = 1'b0;
      out_ready = 1'b1;
   endtask

   initial begin
      logic [63:0] k, d;
      logic        m;
      int          lat;
      bit          stale;
      total = 0;
      bad   = 0;
      reset = 1'b1;
      in_valid = 1'b0; in_mode = 1'b0; in_key = '0; in_data = '0; in_last = 1'b0;
      out_ready = 1'b0;
      b_in_valid = 1'b0; b_in_mode = 1'b0; b_in_key = '0; b_in_data = '0; b_in_last = 1'b0;
      b_out_ready = 1'b1;

      // Reset values
      repeat (3) @(posedge clk);
      #1;
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_out_last", 64'(out_last), 64'd0);
      chk("rst_out_data", out_data, 64'd0);
      chk("rst_in_ready", 64'(in_ready), 64'd1);
      reset = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;

      // Hand-computed single beats
      one_beat("enc_zero", 1'b0, 64'h0, 64'h0, 1'b1, 64'h1234_1234_1234_1234);
      one_beat("enc_k1", 1'b0, 64'h1, 64'h0, 1'b0, 64'h2469_2469_2469_2469);
      one_beat("dec_k1", 1'b1, 64'h1, 64'h2469_2469_2469_2469, 1'b1, 64'h0);
      one_beat("enc_ff", 1'b0, 64'h0, 64'h00FF_00FF_00FF_00FF, 1'b0, 64'h1234_12CB_1234_12CB);
      one_beat("dec_ff", 1'b1, 64'h0, 64'h1234_12CB_1234_12CB, 1'b0, 64'h00FF_00FF_00FF_00FF);
      one_beat("enc_rot2", 1'b0, 64'h0003_0003_0003_0003, 64'h0, 1'b0, 64'h34ED_8D3B_234E_48D3);
      one_beat("enc_fullkey", 1'b0, 64'h0000_0000_0000_FFFF, 64'h0, 1'b0, 64'hEDCB_EDCB_EDCB_EDCB);

      // Eight beats with a three-cycle stall; last only on beat 8
      clear_beats();
      for (int i = 0; i < 8; i++) begin
         k = {$urandom, $urandom};
         d = {$urandom, $urandom};
         push_beat(1'b0, k, d, i == 7, model(1'b0, k, d));
      end
      stream("stall8", 7, 3, 1'b0);

      // Mixed modes with bubbles and a stall
      clear_beats();
      for (int i = 0; i < 60; i++) begin
         k = {$urandom, $urandom};
         d = {$urandom, $urandom};
         m = 1'($urandom_range(0, 1));
         push_beat(m, k, d, 1'($urandom_range(0, 1)), model(m, k, d));
      end
      stream("mixed", 20, 4, 1'b1);

      // Round trip: encrypt a batch, then decrypt it interleaved with fresh encrypts
      clear_beats();
      got_q.delete();
      for (int i = 0; i < 200; i++) begin
         k = {$urandom, $urandom};
         d = {$urandom, $urandom};
         push_beat(1'b0, k, d, 1'b0, model(1'b0, k, d));
      end
      stream("rt_enc", 1000000, 0, 1'b0);
      begin
         logic [63:0] ok[$];
         logic [63:0] od[$];
         logic [63:0] oc[$];
         ok = bk;
         od = bd;
         oc = got_q;
         clear_beats();
         for (int i = 0; i < 200; i++) begin
            push_beat(1'b1, ok[i], oc[i], 1'b0, od[i]);
            k = {$urandom, $urandom};
            d = {$urandom, $urandom};
            push_beat(1'b0, k, d, 1'b1, model(1'b0, k, d));
         end
      end
      stream("rt_dec", 150, 2, 1'b1);
      chk("rt_queue_empty", 64'(exp_q.size()), 64'd0);

      // Reset with three beats in flight, reset winning over an accept
      in_mode = 1'b0; in_key = 64'h1; in_data = 64'h55; in_last = 1'b1;
      in_valid = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk); #1;
      chk("midrst_out_valid", 64'(out_valid), 64'd0);
      chk("midrst_out_data", out_data, 64'd0);
      reset = 1'b0;
      in_valid = 1'b0;
      stale = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         if (out_valid) stale = 1'b1;
      end
      chk("midrst_no_stale", 64'(stale), 64'd0);
      one_beat("post_rst", 1'b0, 64'h1, 64'h0, 1'b1, 64'h2469_2469_2469_2469);

      // 8 lanes of 8 bits: all lanes equal the seed, nine-cycle latency
      chk("w8_rst_valid", 64'(b_out_valid), 64'd0);
      b_in_valid = 1'b1; b_in_mode = 1'b0; b_in_key = '0; b_in_data = '0; b_in_last = 1'b1;
      @(posedge clk); #1;
      b_in_valid = 1'b0;
      lat = 0;
      while (!b_out_valid && lat < 30) begin
         @(posedge clk); #1;
         lat++;
      end
      chk("w8_latency", 64'(lat), 64'd9);
      chk("w8_data", b_out_data, 64'hA5A5_A5A5_A5A5_A5A5);
      chk("w8_last", 64'(b_out_last), 64'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/chain_cipher_pipe.md
# chain_cipher_pipe

Parametrised successor to the fixed 4×16-bit chained XOR/rotate encryptor in the `cryp` IP core. It processes one `LANES*LANE_W`-bit beat per cycle through a lane-serial pipeline. Per-beat mode selects encrypt or decrypt. A valid/ready handshake with full-pipeline stall gives backpressure. It sits between the clear-data packetiser and the encrypted-stream framer, and passes the packet `last` flag alongside the data.

## Interface
Parameters:
- `LANE_W`, 16: lane width in bits, ≥2.
- `LANES`, 4: lanes per beat, ≥1; lane 0 occupies data bits `[LANE_W-1:0]`.
- `IV`, `16'h1234` (width `LANE_W`): chaining seed for lane 0 of every beat.
- `CNT_W`, `$clog2(LANE_W+1)`: popcount width (derived).

Ports:
- `clk` in 1: the only clock.
- `reset` in 1: synchronous, active-high.
- `in_valid` in 1: input beat present.
- `in_ready` out 1: input accepted when `in_valid && in_ready`.
- `in_mode` in 1: 0 = encrypt, 1 = decrypt.
- `in_key` in `LANES*LANE_W`: per-beat key; lane i key is `k_i`.
- `in_data` in `LANES*LANE_W`: clear text (encrypt) or cipher text (decrypt).
- `in_last` in 1: packet-end flag, passed through unmodified.
- `out_valid` out 1: result beat present.
- `out_ready` in 1: downstream accept.
- `out_data` out `LANES*LANE_W`: result.
- `out_last` out 1: delayed `in_last`.

## Operation
- Per lane: `n_i = popcount(k_i) mod LANE_W`. `rotl`/`rotr` rotate within `LANE_W` bits.
- Encrypt: `p_0 = IV`, `p_i = c_{i-1}`, and `c_i = rotl(d_i ^ p_i, n_i) ^ k_i`. This is a strict chain; lane i needs lane i-1's result.
- Decrypt: `p_0 = IV`, `p_i = d_{i-1}` (input cipher lane), and `o_i = rotr(d_i ^ k_i, n_i) ^ p_i`. The decrypt chain value is taken from the input, but the lane schedule is identical so latency is mode-independent.
- Pipeline stages:
  - S0 registers data, key, mode and last, plus all `LANES` popcounts.
  - Stage j (1..LANES) computes lane j-1 from S0-delayed data, key and popcount, and the chain value from stage j-1.
  - Finished lanes are carried forward in delay registers so all lanes align at stage `LANES`.
- Arithmetic is pure bitwise; no carries. A popcount of exactly `LANE_W` rotates by 0.
- The beat's mode travels with it; mixed encrypt/decrypt beats may be back-to-back.
- Each stage has its own valid bit. `last` travels with valid.
- Flow control:
  - Global advance `adv = !out_valid || out_ready`.
  - `in_ready = adv`. This is a combinational path from `out_ready`; it is accepted.
  - When `adv` is 0, every stage register holds.
- Reset: all stage valids and `out_last` clear; `out_data` clears to 0. Other data registers are not reset.

## Timing
- Reset values: `out_valid`=0, `out_last`=0, `out_data`=0, `in_ready`=1.
- Latency: a beat accepted at edge t appears with `out_valid`=1 after edge t+`LANES`+1, which is 5 cycles at default. This matches the previous-generation core.
- Throughput: 1 beat/cycle while `out_ready`=1.
- Stall: `out_ready`=0 with `out_valid`=1 freezes the pipe. `out_data`/`out_last` stay stable, `in_ready`=0, and no beat is dropped or duplicated.
- Bubbles: beats with `in_valid`=0 propagate as invalid stages. `out_valid` drops for exactly the bubble's cycles.
- Reset mid-operation: all in-flight beats are discarded. `out_valid`=0 in the cycle after the reset edge; nothing is emitted for pre-reset beats.
- `reset` has priority over `adv` in the same cycle.

## Structure
- Package `cryp_pkg`:
  - `CRYP_IV_DEFAULT = 16'h1234`.
  - `MODE_ENC`/`MODE_DEC` constants.
  - Function `popcount`.
  - Functions `rotl`/`rotr`, parametrised by width.
- Sub-module `chain_cipher_lane`: one combinational lane (data, key, count, chain in → result). It is instantiated `LANES` times in a generate loop; the top owns all registers and handshake.

## Test plan
- Key all 0, data all 0, encrypt, default params: `out_data`=`64'h1234_1234_1234_1234` after 5 cycles.
- Key lane0 `16'h0001`, other key lanes 0, data 0, encrypt: `out_data`=`64'h2469_2469_2469_2469`.
- Feed the previous result back with the same key, decrypt: `out_data`=0. Repeat with 1000 random key/data beats, mixed modes interleaved; decrypt(encrypt(x))=x every time.
- Stream 8 beats, `out_ready` low for 3 cycles mid-stream: output stable while stalled, `in_ready`=0, all 8 beats delivered in order; `out_last` only on beat 8.
- Assert `reset` with 3 beats in flight: no stale beat emitted; the first post-reset beat emerges with exactly 5-cycle latency.
- `LANE_W`=8, `LANES`=8, `IV`=`8'hA5`, key/data 0, encrypt: every lane = `8'hA5`; latency 9 cycles.
